// File: rtl/hssi_tc_mailbox_bridge.sv
// Bridges the 4-register AFU traffic-controller mailbox (CMD/ADDRESS/RDDATA/WRDATA)
// onto single read/write transactions of the HSSI traffic controller register bus.
module hssi_tc_mailbox_bridge #(
    parameter int unsigned TC_ADDR_W   = 16,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [31:0] ERR_RDDATA  = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 csr_wr,
    input  logic                 csr_rd,
    input  logic [3:0]           csr_addr,
    input  logic [31:0]          csr_wrdata,
    output logic [31:0]          csr_rddata,
    output logic                 csr_rdvalid,
    output logic                 tc_rd,
    output logic                 tc_wr,
    output logic [TC_ADDR_W-1:0] tc_addr,
    output logic [31:0]          tc_wrdata,
    input  logic                 tc_waitrequest,
    input  logic [31:0]          tc_rddata,
    input  logic                 tc_rddatavalid,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [3:0] OFF_CMD    = 4'h0;
    localparam logic [3:0] OFF_ADDR   = 4'h4;
    localparam logic [3:0] OFF_RDDATA = 4'h8;
    localparam logic [3:0] OFF_WRDATA = 4'hC;

    localparam logic [1:0] OP_RD = 2'd1;
    localparam logic [1:0] OP_WR = 2'd2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StDone
    } state_e;

    state_e           state_q;
    logic [31:0]      addr_q;
    logic [31:0]      wrdata_q;
    logic [31:0]      rddata_q;
    logic             rd_pend_q;
    logic             wr_pend_q;
    logic             ack_q;
    logic             timeout_err_q;
    logic             busy_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tc_rd_q;
    logic             tc_wr_q;

    logic        cmd_wr;
    logic [1:0]  cmd_op;
    logic        cmd_start;
    logic        cmd_noop;
    logic        timeout_hit;
    logic        in_flight;
    logic [31:0] status;
    logic [31:0] rd_mux;

    always_comb begin
        cmd_wr      = csr_wr && (csr_addr == OFF_CMD);
        cmd_op      = csr_wrdata[1:0];
        cmd_start   = cmd_wr && ((cmd_op == OP_RD) || (cmd_op == OP_WR));
        // Opcode 3 is illegal and behaves exactly like NOOP.
        cmd_noop    = cmd_wr && !cmd_start;
        timeout_hit = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));
        in_flight   = (state_q == StIssue) || (state_q == StWaitRd);
        status      = {27'b0, busy_err_q, timeout_err_q, ack_q, wr_pend_q, rd_pend_q};
    end

    always_comb begin
        rd_mux = '0;
        case (csr_addr)
            OFF_CMD:    rd_mux = status;
            OFF_ADDR:   rd_mux = addr_q;
            OFF_RDDATA: rd_mux = rddata_q;
            OFF_WRDATA: rd_mux = wrdata_q;
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wrdata_q      <= '0;
            rddata_q      <= '0;
            rd_pend_q     <= 1'b0;
            wr_pend_q     <= 1'b0;
            ack_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_err_q    <= 1'b0;
            cnt_q         <= '0;
            tc_rd_q       <= 1'b0;
            tc_wr_q       <= 1'b0;
        end else begin
            if (cmd_noop) begin
                ack_q         <= 1'b0;
                timeout_err_q <= 1'b0;
                busy_err_q    <= 1'b0;
            end

            if (cmd_start && (state_q != StIdle)) begin
                busy_err_q <= 1'b1;
            end

            // Counter saturates at the limit so a late acceptance still times out in WAIT_RD.
            if (in_flight && !timeout_hit) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (csr_wr && (csr_addr == OFF_ADDR)) begin
                        addr_q <= csr_wrdata;
                    end
                    if (csr_wr && (csr_addr == OFF_WRDATA)) begin
                        wrdata_q <= csr_wrdata;
                    end
                    if (cmd_start) begin
                        state_q       <= StIssue;
                        ack_q         <= 1'b0;
                        timeout_err_q <= 1'b0;
                        rd_pend_q     <= (cmd_op == OP_RD);
                        wr_pend_q     <= (cmd_op == OP_WR);
                        tc_rd_q       <= (cmd_op == OP_RD);
                        tc_wr_q       <= (cmd_op == OP_WR);
                        cnt_q         <= '0;
                    end
                end

                StIssue: begin
                    if (!tc_waitrequest) begin
                        tc_rd_q <= 1'b0;
                        tc_wr_q <= 1'b0;
                        if (wr_pend_q) begin
                            state_q <= StDone;
                        end else if (tc_rddatavalid) begin
                            rddata_q <= tc_rddata;
                            state_q  <= StDone;
                        end else begin
                            state_q <= StWaitRd;
                        end
                    end else if (timeout_hit) begin
                        tc_rd_q       <= 1'b0;
                        tc_wr_q       <= 1'b0;
                        timeout_err_q <= 1'b1;
                        ack_q         <= 1'b1;
                        rd_pend_q     <= 1'b0;
                        wr_pend_q     <= 1'b0;
                        if (rd_pend_q) begin
                            rddata_q <= ERR_RDDATA;
                        end
                        state_q <= StIdle;
                    end
                end

                StWaitRd: begin
                    if (tc_rddatavalid) begin
                        rddata_q <= tc_rddata;
                        state_q  <= StDone;
                    end else if (timeout_hit) begin
                        timeout_err_q <= 1'b1;
                        ack_q         <= 1'b1;
                        rd_pend_q     <= 1'b0;
                        wr_pend_q     <= 1'b0;
                        rddata_q      <= ERR_RDDATA;
                        state_q       <= StIdle;
                    end
                end

                StDone: begin
                    ack_q     <= 1'b1;
                    rd_pend_q <= 1'b0;
                    wr_pend_q <= 1'b0;
                    state_q   <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    // Read response is registered from pre-edge state, so a same-cycle CMD write is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            csr_rdvalid <= 1'b0;
            csr_rddata  <= '0;
        end else begin
            csr_rdvalid <= csr_rd;
            csr_rddata  <= csr_rd ? rd_mux : '0;
        end
    end

    assign tc_rd     = tc_rd_q;
    assign tc_wr     = tc_wr_q;
    assign tc_addr   = addr_q[TC_ADDR_W-1:0];
    assign tc_wrdata = wrdata_q;
    assign busy      = (state_q != StIdle);

endmodule
